// File: rtl/si53xx_spi_pkg.sv
// Shared opcodes, register map constants and FSM encoding for the Si53xx
// SPI link (master and in-fabric responder).
package si53xx_spi_pkg;

   localparam logic [7:0] CMD_SET_ADDR  = 8'h00;
   localparam logic [7:0] CMD_WRITE     = 8'h40;
   localparam logic [7:0] CMD_WRITE_INC = 8'h60;
   localparam logic [7:0] CMD_READ      = 8'h80;
   localparam logic [7:0] CMD_READ_INC  = 8'hA0;
   localparam logic [7:0] CMD_BURST     = 8'hE0;

   localparam logic [7:0] PAGE_REG_ADDR = 8'h01;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_SETADDR,
      ST_WDATA,
      ST_RDATA,
      ST_BADDR,
      ST_BDATA,
      ST_DONE,
      ST_ERR
   } spi_state_e;

   function automatic logic is_inc_cmd(input logic [7:0] c);
      return (c == CMD_WRITE_INC) || (c == CMD_READ_INC);
   endfunction

endpackage

// File: rtl/si53xx_spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin with rise/fall
// detection on the synchronized level.
module si53xx_spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/si53xx_spi_responder.sv
// Si53xx-compatible SPI slave with a paged byte register file, used as an
// in-fabric stand-in for the clock chip during master bring-up.
module si53xx_spi_responder
   import si53xx_spi_pkg::*;
#(
   parameter int         PAGE_W    = 2,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              nCS,
   input  logic              sclk,
   input  logic              sdi,
   output logic              sdo,
   output logic              sdo_oe,
   output logic              wr_strobe,
   output logic [PAGE_W+7:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic [PAGE_W+7:0] dbg_addr,
   output logic [7:0]        dbg_data
);

   localparam int AW    = PAGE_W + 8;
   localparam int DEPTH = 1 << AW;

   logic ncs_s, ncs_rise, ncs_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic sdi_meta_q, sdi_s_q;

   spi_state_e state_q, state_d;

   logic [2:0]        bitcnt_q;
   logic [7:0]        rx_q;
   logic [7:0]        tx_q;
   logic [7:0]        addr_q, addr_d;
   logic [PAGE_W-1:0] page_q;
   logic              inc_q, inc_d;
   logic              fetch_q, fetch;
   logic              wr_en;
   logic              sdo_q;
   logic              wr_strobe_q;
   logic [AW-1:0]     wr_addr_q;
   logic [7:0]        wr_data_q;
   logic [7:0]        dbg_data_q;
   logic [7:0]        mem_q [DEPTH];

   logic          active;
   logic          byte_v;
   logic [7:0]    rx_byte;
   logic [AW-1:0] cur_addr;

   si53xx_spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (sclk),
      .q_o    (sclk_s),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   si53xx_spi_sync_edge #(.RST_VAL(1'b1)) u_ncs_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (nCS),
      .q_o    (ncs_s),
      .rise_o (ncs_rise),
      .fall_o (ncs_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sdi_meta_q <= 1'b0;
         sdi_s_q    <= 1'b0;
      end else begin
         sdi_meta_q <= sdi;
         sdi_s_q    <= sdi_meta_q;
      end
   end

   // The page register lives outside the array and shadows 0x01 on every page.
   function automatic logic [7:0] rd_byte(input logic [AW-1:0] a);
      if (a[7:0] == PAGE_REG_ADDR) return 8'(page_q);
      return mem_q[a];
   endfunction

   assign active   = ~ncs_s & (state_q != ST_IDLE);
   assign byte_v   = sclk_rise & active & (bitcnt_q == 3'd7);
   assign rx_byte  = {rx_q[6:0], sdi_s_q};
   assign cur_addr = {page_q, addr_q};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inc_d   = inc_q;
      fetch   = 1'b0;
      wr_en   = 1'b0;
      if (ncs_s) begin
         state_d = ST_IDLE;
      end else if (ncs_fall) begin
         // Mode 0 only: a frame opening with SCLK high cannot be framed.
         state_d = sclk_s ? ST_ERR : ST_CMD;
      end else if (byte_v) begin
         unique case (state_q)
            ST_CMD: begin
               inc_d = is_inc_cmd(rx_byte);
               unique case (rx_byte)
                  CMD_SET_ADDR:  state_d = ST_SETADDR;
                  CMD_WRITE:     state_d = ST_WDATA;
                  CMD_WRITE_INC: state_d = ST_WDATA;
                  CMD_READ: begin
                     state_d = ST_RDATA;
                     fetch   = 1'b1;
                  end
                  CMD_READ_INC: begin
                     state_d = ST_RDATA;
                     fetch   = 1'b1;
                  end
                  CMD_BURST:     state_d = ST_BADDR;
                  default:       state_d = ST_ERR;
               endcase
            end
            ST_SETADDR: begin
               addr_d  = rx_byte;
               state_d = ST_DONE;
            end
            ST_WDATA: begin
               wr_en   = 1'b1;
               state_d = ST_DONE;
               if (inc_q) addr_d = addr_q + 8'd1;
            end
            ST_RDATA: begin
               state_d = ST_DONE;
               if (inc_q) addr_d = addr_q + 8'd1;
            end
            ST_BADDR: begin
               addr_d  = rx_byte;
               state_d = ST_BDATA;
            end
            ST_BDATA: begin
               wr_en  = 1'b1;
               addr_d = addr_q + 8'd1;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= 8'h00;
         page_q      <= '0;
         inc_q       <= 1'b0;
         fetch_q     <= 1'b0;
         bitcnt_q    <= 3'd0;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         sdo_q       <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
         dbg_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         inc_q       <= inc_d;
         fetch_q     <= fetch;
         wr_strobe_q <= wr_en;
         if (ncs_fall) begin
            bitcnt_q <= 3'd0;
         end else if (sclk_rise && active) begin
            rx_q     <= rx_byte;
            bitcnt_q <= bitcnt_q + 3'd1;
         end
         if (wr_en) begin
            wr_addr_q <= cur_addr;
            wr_data_q <= rx_byte;
            if (addr_q == PAGE_REG_ADDR) page_q <= rx_byte[PAGE_W-1:0];
         end
         if (fetch_q) begin
            tx_q <= rd_byte(cur_addr);
         end else if (sclk_fall && !ncs_s && state_q == ST_RDATA) begin
            tx_q <= {tx_q[6:0], 1'b0};
         end
         if (ncs_rise) begin
            sdo_q <= 1'b0;
         end else if (sclk_fall) begin
            sdo_q <= (!ncs_s && state_q == ST_RDATA) ? tx_q[7] : 1'b0;
         end
         dbg_data_q <= rd_byte(dbg_addr);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      end else if (wr_en && addr_q != PAGE_REG_ADDR) begin
         mem_q[cur_addr] <= rx_byte;
      end
   end

   assign sdo       = sdo_q;
   assign sdo_oe    = ~ncs_s;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_si53xx_spi_responder.sv
// Directed bench for si53xx_spi_responder: bit-banged mode-0 master,
// write scoreboard checked on every wr_strobe, backdoor readback.
module tb_si53xx_spi_responder;
   import si53xx_spi_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       nCS = 1'b1;
   logic       sclk = 1'b0;
   logic       sdi = 1'b0;
   logic       sdo, sdo_oe, wr_strobe;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;
   logic [9:0] dbg_addr = 10'h000;
   logic [7:0] dbg_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] rd_q[$];
   wr_t        mon_e;
   logic [7:0] r;
   logic [7:0] e;

   si53xx_spi_responder #(.PAGE_W(2), .RESET_VAL(8'h00)) dut (
      .clk       (clk),
      .reset     (reset),
      .nCS       (nCS),
      .sclk      (sclk),
      .sdi       (sdi),
      .sdo       (sdo),
      .sdo_oe    (sdo_oe),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wr_strobe) begin
         chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
         if (wr_q.size() != 0) begin
            mon_e = wr_q.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
            chk("wr_data", 32'(wr_data), 32'(mon_e.d));
         end
      end
   end

   task automatic xfer(input logic [7:0] tx, input int nbits,
                       output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         sdi = tx[i];
         repeat (5) @(negedge clk);
         rx[i] = sdo;
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic frame_start;
      nCS = 1'b0;
      repeat (5) @(negedge clk);
      chk("sdo_oe_sel", 32'(sdo_oe), 32'd1);
   endtask

   task automatic frame_end;
      repeat (5) @(negedge clk);
      nCS = 1'b1;
      repeat (10) @(negedge clk);
      chk("sdo_oe_desel", 32'(sdo_oe), 32'd0);
   endtask

   task automatic frame2(input logic [7:0] b0, input logic [7:0] b1,
                         output logic [7:0] r1);
      logic [7:0] r0;
      frame_start();
      xfer(b0, 8, r0);
      xfer(b1, 8, r1);
      frame_end();
   endtask

   task automatic dbg_chk(input string tag, input logic [9:0] a,
                          input logic [7:0] exp);
      dbg_addr = a;
      @(negedge clk);
      chk(tag, 32'(dbg_data), 32'(exp));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sdo", 32'(sdo), 32'd0);
      chk("rst_sdo_oe", 32'(sdo_oe), 32'd0);
      chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_dbg_data", 32'(dbg_data), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      frame2(CMD_SET_ADDR, 8'hAA, r);
      wr_q.push_back('{10'h0AA, 8'hA6});
      frame2(CMD_WRITE, 8'hA6, r);
      dbg_chk("dbg_0AA", 10'h0AA, 8'hA6);

      frame2(CMD_SET_ADDR, 8'h10, r);
      wr_q.push_back('{10'h010, 8'h5C});
      frame2(CMD_WRITE_INC, 8'h5C, r);
      wr_q.push_back('{10'h011, 8'h3E});
      frame2(CMD_WRITE, 8'h3E, r);
      frame2(CMD_SET_ADDR, 8'h10, r);
      rd_q.push_back(8'h5C);
      frame2(CMD_READ_INC, 8'h00, r);
      e = rd_q.pop_front();
      chk("rd_inc_010", 32'(r), 32'(e));
      rd_q.push_back(8'h3E);
      frame2(CMD_READ, 8'h00, r);
      e = rd_q.pop_front();
      chk("rd_011", 32'(r), 32'(e));
      rd_q.push_back(8'h3E);
      frame2(CMD_READ, 8'h00, r);
      e = rd_q.pop_front();
      chk("rd_no_inc", 32'(r), 32'(e));

      wr_q.push_back('{10'h0FE, 8'h11});
      wr_q.push_back('{10'h0FF, 8'h22});
      wr_q.push_back('{10'h000, 8'h33});
      frame_start();
      xfer(CMD_BURST, 8, r);
      xfer(8'hFE, 8, r);
      xfer(8'h11, 8, r);
      xfer(8'h22, 8, r);
      xfer(8'h33, 8, r);
      frame_end();
      chk("burst_all_written", 32'(wr_q.size()), 32'd0);
      dbg_chk("dbg_0FE", 10'h0FE, 8'h11);
      dbg_chk("dbg_0FF", 10'h0FF, 8'h22);
      dbg_chk("dbg_000", 10'h000, 8'h33);

      frame2(CMD_SET_ADDR, 8'h30, r);
      frame_start();
      xfer(CMD_WRITE, 8, r);
      xfer(8'h5A, 5, r);
      frame_end();
      dbg_chk("abort_no_write", 10'h030, 8'h00);
      wr_q.push_back('{10'h030, 8'h6B});
      frame2(CMD_WRITE, 8'h6B, r);
      dbg_chk("addr_kept", 10'h030, 8'h6B);

      frame_start();
      xfer(8'h13, 8, r);
      chk("illegal_sdo_b0", 32'(r), 32'd0);
      xfer(8'hFF, 8, r);
      chk("illegal_sdo_b1", 32'(r), 32'd0);
      frame_end();
      dbg_chk("illegal_no_write", 10'h030, 8'h6B);

      frame2(CMD_SET_ADDR, PAGE_REG_ADDR, r);
      wr_q.push_back('{10'h001, 8'h02});
      frame2(CMD_WRITE, 8'h02, r);
      frame2(CMD_SET_ADDR, 8'h20, r);
      wr_q.push_back('{10'h220, 8'h77});
      frame2(CMD_WRITE, 8'h77, r);
      dbg_chk("dbg_220", 10'h220, 8'h77);
      dbg_chk("dbg_020", 10'h020, 8'h00);
      frame2(CMD_SET_ADDR, PAGE_REG_ADDR, r);
      rd_q.push_back(8'h02);
      frame2(CMD_READ, 8'h00, r);
      e = rd_q.pop_front();
      chk("rd_page", 32'(r), 32'(e));

      frame_start();
      xfer(CMD_BURST, 8, r);
      xfer(8'h40, 8, r);
      wr_q.push_back('{10'h240, 8'h99});
      xfer(8'h99, 8, r);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_sdo", 32'(sdo), 32'd0);
      chk("mid_rst_sdo_oe", 32'(sdo_oe), 32'd0);
      chk("mid_rst_wr_strobe", 32'(wr_strobe), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
      chk("mid_rst_dbg_data", 32'(dbg_data), 32'd0);
      frame_end();
      dbg_chk("rst_mem_240", 10'h240, 8'h00);
      dbg_chk("rst_mem_0AA", 10'h0AA, 8'h00);
      dbg_chk("rst_page", 10'h001, 8'h00);
      wr_q.push_back('{10'h000, 8'h5A});
      frame2(CMD_WRITE, 8'h5A, r);
      dbg_chk("post_rst_000", 10'h000, 8'h5A);

      chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/si53xx_spi_responder.md
Name: si53xx_spi_responder

Overview:
- Synthesizable SPI slave that implements the Si53xx (Si5396A) 4-wire SPI command set.
- It is the device end of the link driven by si53xx_spi_interface.
- Used as an in-fabric stand-in for the clock chip, for bench and loopback bring-up of the master and its ROM-driven configuration sequence.
- Holds a paged byte register file. Oversamples SCLK/nCS/SDI on the system clock.

Parameters:
PAGE_W, 2, page-number bits implemented; register file depth is 2^PAGE_W * 256 bytes.
RESET_VAL, 8'h00, value every register file byte is cleared to on reset.

Ports:
clk  input  1  system clock; SCLK period is ≥ 8 clk periods.
reset  input  1  synchronous, active-high reset.
nCS  input  1  chip select from master, active low, asynchronous to clk.
sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous.
sdi  input  1  data from master (master's sdo), MSB first.
sdo  output  1  data to master (master's sdi).
sdo_oe  output  1  high while the synchronized nCS is low.
wr_strobe  output  1  one-cycle pulse per committed register write.
wr_addr  output  PAGE_W+8  {page, addr} of the committed write.
wr_data  output  8  data of the committed write.
dbg_addr  input  PAGE_W+8  backdoor read address.
dbg_data  output  8  backdoor read data, registered, 1-cycle latency.

Behaviour:
- Reset values:
  - sdo=0, sdo_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, dbg_data=0.
  - Address reg=0, page reg=0, FSM=IDLE, bit counter=0.
  - All register bytes = RESET_VAL. Reset is honoured mid-transaction.
- Input synchronization:
  - Two-flop synchronizer on nCS, sclk and sdi.
  - Edge detect on the synchronized sclk: rise = sample, fall = shift.
- Byte reception:
  - On each rise with nCS low, shift sdi into the receive register, MSB first.
  - On the 8th rise, present the byte to the FSM.
- Commands (first byte after nCS falls):
  - 0x00 set-address
  - 0x40 write
  - 0x80 read
  - 0x60 write+inc
  - 0xA0 read+inc
  - 0xE0 burst write
  - Any other value goes to ERR.
- FSM states: IDLE, CMD, SETADDR, WDATA, RDATA, BADDR, BDATA, DONE, ERR.
  - nCS falling → CMD; bit counter cleared.
  - CMD byte: 0x00→SETADDR; 0x40/0x60→WDATA; 0x80/0xA0→RDATA (register fetched next clk); 0xE0→BADDR.
  - SETADDR byte → address reg ← byte; → DONE.
  - WDATA byte → write mem[{page,addr}]; if 0x60, addr++; → DONE.
  - RDATA: the byte is shifted out; after its 8th rise, if 0xA0, addr++; → DONE.
  - BADDR byte → address reg ← byte; → BDATA.
  - BDATA byte → write mem[{page,addr}]; addr++; stay in BDATA.
  - DONE/ERR: further bytes are ignored, sdo=0, no writes.
  - nCS rising (any state) → IDLE. A partial byte is discarded with no write; the address reg keeps its last value.
- Page register:
  - Address 0x01 on every page is the page register.
  - A write to it updates the page (low PAGE_W bits stored, upper bits read back 0).
  - A read of it returns the page.
- Address increment is 8-bit and wraps 0xFF→0x00 within the current page; the page is unchanged.
- Read output timing:
  - Bit 7 of read data drives sdo on the first sclk fall after the command's 8th rise.
  - The following falls shift bits 6..0.
  - sdo changes only on falls.
- Every committed write pulses wr_strobe for exactly 1 clk, with wr_addr/wr_data valid in the same cycle.
- Backdoor read (dbg) and SPI write to the same address in the same cycle: dbg_data returns the old value.

Decomposition:
- Package si53xx_spi_pkg:
  - command opcodes (CMD_SET_ADDR=8'h00, CMD_WRITE=8'h40, CMD_WRITE_INC=8'h60, CMD_READ=8'h80, CMD_READ_INC=8'hA0, CMD_BURST=8'hE0)
  - PAGE_REG_ADDR=8'h01
  - FSM state encoding
- The package is shared with si53xx_spi_interface.
- One sub-module, si53xx_spi_sync_edge: 2-FF synchronizer plus rise/fall detect, instantiated once for sclk and reused for nCS.

Test Plan:
- Set-address then write: frame 0x00,0xAA; then frame 0x40,0xA6 → one wr_strobe, wr_addr=0x0AA, wr_data=0xA6; dbg read at 0x0AA returns 0xA6.
- Read and read+inc: preload 0x10=0x5C and 0x11=0x3E; frame 0x00,0x10; then 0xA0 plus 8 dummy clocks → sdo bits 01011100. A second 0x80 read returns 0x3E.
- Burst with wrap: frame 0xE0,0xFE,0x11,0x22,0x33 → bytes 0x0FE=0x11, 0x0FF=0x22, 0x000=0x33; exactly 3 wr_strobe pulses.
- Paging: set-address 0x01, write 0x02, then set-address 0x20, write 0x77 → wr_addr=0x220. Reading addr 0x01 returns 0x02.
- Aborts: nCS raised after 5 bits of a write data byte → no wr_strobe. An illegal opcode 0x13 followed by 0xFF → no write, sdo=0 throughout.
- Reset mid-burst: assert reset for 1 clk during BDATA → all outputs return to reset values, mem=RESET_VAL, next frame decodes normally.
